// File: rtl/mcb_write_arbiter.sv
// Round-robin write arbiter sharing one MCB user port between two burst requesters.
// Each grant streams one burst into the write FIFO, then issues its write command.
module mcb_write_arbiter #(
    parameter int BURST_MAX  = 32,
    parameter int ADDR_WIDTH = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  calib_done,
    input  logic                  r0_req,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [5:0]            r0_len,
    input  logic [31:0]           r0_data,
    input  logic                  r0_valid,
    output logic                  r0_ready,
    output logic                  r0_done,
    output logic                  r0_err,
    input  logic                  r1_req,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [5:0]            r1_len,
    input  logic [31:0]           r1_data,
    input  logic                  r1_valid,
    output logic                  r1_ready,
    output logic                  r1_done,
    output logic                  r1_err,
    output logic                  busy,
    output logic                  cmd_en,
    output logic [2:0]            cmd_instr,
    output logic [5:0]            cmd_bl,
    output logic [ADDR_WIDTH-1:0] cmd_byte_addr,
    input  logic                  cmd_full,
    output logic                  wr_en,
    output logic [31:0]           wr_data,
    output logic [3:0]            wr_mask,
    input  logic                  wr_full
);

    typedef enum logic [1:0] {
        IDLE,
        WRDATA,
        CMD,
        DONE
    } state_t;

    localparam logic [6:0] MAX_LEN = 7'(BURST_MAX);
    localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(3);

    state_t                state;
    logic                  gnt;
    logic                  last_grant;
    logic                  err;
    logic [5:0]            cnt;
    logic                  sel;
    logic [5:0]            sel_len;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  in_wr;
    logic                  wr_ok;

    // Both requesting: the one not served last wins; otherwise whoever asks.
    always_comb begin
        sel = r1_req;
        if (r0_req && r1_req)
            sel = ~last_grant;
        sel_len  = sel ? r1_len : r0_len;
        sel_addr = sel ? r1_addr : r0_addr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            gnt           <= 1'b0;
            last_grant    <= 1'b1;
            err           <= 1'b0;
            cnt           <= '0;
            cmd_bl        <= '0;
            cmd_byte_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (calib_done && (r0_req || r1_req)) begin
                        gnt        <= sel;
                        last_grant <= sel;
                        cnt        <= '0;
                        if ({1'b0, sel_len} >= MAX_LEN) begin
                            // Rejected bursts leave the command outputs untouched.
                            err   <= 1'b1;
                            state <= DONE;
                        end else begin
                            err           <= 1'b0;
                            cmd_bl        <= sel_len;
                            cmd_byte_addr <= sel_addr & ALIGN;
                            state         <= WRDATA;
                        end
                    end
                end
                WRDATA: begin
                    if (wr_en) begin
                        if (cnt == cmd_bl)
                            state <= CMD;
                        else
                            cnt <= cnt + 6'd1;
                    end
                end
                CMD: begin
                    if (!cmd_full)
                        state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_wr = (state == WRDATA);
    assign wr_ok = in_wr && !wr_full;

    assign r0_ready = wr_ok && !gnt;
    assign r1_ready = wr_ok && gnt;
    assign wr_en    = gnt ? (r1_valid && r1_ready) : (r0_valid && r0_ready);
    assign wr_data  = !in_wr ? '0 : (gnt ? r1_data : r0_data);
    assign wr_mask  = 4'b0000;

    assign cmd_en    = (state == CMD) && !cmd_full;
    assign cmd_instr = 3'b000;

    assign busy    = (state != IDLE);
    assign r0_done = (state == DONE) && !gnt;
    assign r1_done = (state == DONE) && gnt;
    assign r0_err  = r0_done && err;
    assign r1_err  = r1_done && err;

endmodule

// File: tb/tb_mcb_write_arbiter.sv
// Directed bench for mcb_write_arbiter: burst streaming, fairness, stalls,
// rejection, address alignment, calibration gating and mid-burst reset.
module tb_mcb_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        calib_done;
    logic        r0_req, r1_req;
    logic [29:0] r0_addr, r1_addr;
    logic [5:0]  r0_len, r1_len;
    logic [31:0] r0_data, r1_data;
    logic        r0_valid, r1_valid;
    logic        r0_ready, r1_ready;
    logic        r0_done, r1_done;
    logic        r0_err, r1_err;
    logic        busy;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        cmd_full;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;
    logic        wr_full;

    int checks = 0;
    int failures = 0;

    logic [31:0] idx0 = 0, idx1 = 0;
    logic [31:0] off0 = 0, off1 = 0;
    logic [31:0] dbase0 = 0, dbase1 = 0;

    logic [31:0] push_q[$];
    int          grant_q[$];
    int          cmds = 0;

    mcb_write_arbiter #(.BURST_MAX(32), .ADDR_WIDTH(30)) dut (
        .clk(clk), .reset(reset), .calib_done(calib_done),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_len(r0_len),
        .r0_data(r0_data), .r0_valid(r0_valid), .r0_ready(r0_ready),
        .r0_done(r0_done), .r0_err(r0_err),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_len(r1_len),
        .r1_data(r1_data), .r1_valid(r1_valid), .r1_ready(r1_ready),
        .r1_done(r1_done), .r1_err(r1_err),
        .busy(busy), .cmd_en(cmd_en), .cmd_instr(cmd_instr),
        .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
        .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask), .wr_full(wr_full)
    );

    always #5 clk = ~clk;

    // Requester data sources: each accepted word advances its own index.
    assign r0_data = dbase0 + (idx0 - off0);
    assign r1_data = dbase1 + (idx1 - off1);

    always @(posedge clk) begin
        if (r0_valid && r0_ready) idx0 <= idx0 + 1;
        if (r1_valid && r1_ready) idx1 <= idx1 + 1;
    end

    always @(negedge clk) begin
        if (wr_en) push_q.push_back(wr_data);
        if (cmd_en) cmds = cmds + 1;
        if (r0_done) grant_q.push_back(0);
        if (r1_done) grant_q.push_back(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int p0, c0, g0, nd;

    initial begin
        reset = 1; calib_done = 1;
        r0_req = 0; r0_addr = 0; r0_len = 0; r0_valid = 0;
        r1_req = 0; r1_addr = 0; r1_len = 0; r1_valid = 0;
        cmd_full = 0; wr_full = 0;
        cyc(); cyc();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_cmd_en", cmd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_ready", {r0_ready, r1_ready}, 0);
        chk("rst_done", {r0_done, r1_done, r0_err, r1_err}, 0);
        chk("rst_cmd_bl", cmd_bl, 0);
        chk("rst_cmd_addr", cmd_byte_addr, 0);
        chk("rst_const", {cmd_instr, wr_mask}, 0);

        // Single burst: r0 len=3 at 0x100
        cyc(); reset = 0;
        cyc();
        p0 = push_q.size(); c0 = cmds;
        off0 = idx0; dbase0 = 32'hA0;
        r0_req = 1; r0_addr = 30'h100; r0_len = 3; r0_valid = 1;
        #1;
        chk("b1_idle_busy", busy, 0);
        chk("b1_idle_ready", r0_ready, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            chk("b1_wr_en", wr_en, 1);
            chk("b1_wr_data", wr_data, 32'hA0 + k);
            chk("b1_r1_ready", r1_ready, 0);
        end
        cyc(); #1;
        chk("b1_cmd_en", cmd_en, 1);
        chk("b1_cmd_bl", cmd_bl, 3);
        chk("b1_cmd_addr", cmd_byte_addr, 30'h100);
        chk("b1_cmd_wr_en", wr_en, 0);
        cyc(); r0_req = 0; r0_valid = 0; #1;
        chk("b1_done", {r0_done, r0_err}, 2'b10);
        chk("b1_done_cmd_en", cmd_en, 0);
        cyc(); #1;
        chk("b1_idle_after", busy, 0);
        chk("b1_pushes", push_q.size() - p0, 4);
        chk("b1_cmds", cmds - c0, 1);

        // Fairness: both request continuously, 2-word bursts
        reset = 1;
        cyc(); cyc(); reset = 0;
        p0 = push_q.size(); c0 = cmds; g0 = grant_q.size();
        off0 = idx0; off1 = idx1;
        dbase0 = 32'h1000_0000; dbase1 = 32'h2000_0000;
        r0_req = 1; r0_addr = 30'h40; r0_len = 1; r0_valid = 1;
        r1_req = 1; r1_addr = 30'h80; r1_len = 1; r1_valid = 1;
        nd = 0;
        for (int c = 0; c < 200 && nd < 6; c++) begin
            cyc();
            if (r0_done || r1_done) begin
                nd++;
                if (nd == 6) begin
                    r0_req = 0; r1_req = 0; r0_valid = 0; r1_valid = 0;
                end
            end
        end
        cyc(); cyc(); #1;
        chk("rr_done_count", nd, 6);
        chk("rr_grants", grant_q.size() - g0, 6);
        for (int b = 0; b < 6; b++)
            chk("rr_order", grant_q[g0 + b], b % 2);
        chk("rr_pushes", push_q.size() - p0, 12);
        for (int b = 0; b < 6; b++)
            for (int w = 0; w < 2; w++)
                chk("rr_data", push_q[p0 + b*2 + w],
                    ((b % 2) ? 32'h2000_0000 : 32'h1000_0000) + (b/2)*2 + w);
        chk("rr_cmds", cmds - c0, 6);

        // wr_full stall mid-burst, then cmd_full hold-off
        cyc();
        p0 = push_q.size(); c0 = cmds;
        off0 = idx0; dbase0 = 32'h3000_0000;
        r0_req = 1; r0_addr = 30'h200; r0_len = 3; r0_valid = 1;
        cyc(); #1;
        chk("st_first_push", wr_en, 1);
        cyc(); wr_full = 1; #1;
        chk("st_full_ready", r0_ready, 0);
        chk("st_full_wr_en", wr_en, 0);
        repeat (4) begin
            cyc(); #1;
            chk("st_full_wr_en", wr_en, 0);
        end
        cyc(); wr_full = 0; #1;
        chk("st_resume", wr_en, 1);
        chk("st_resume_data", wr_data, 32'h3000_0001);
        cyc(); cyc(); #1;
        chk("st_last_data", wr_data, 32'h3000_0003);
        cyc(); cmd_full = 1; #1;
        chk("st_cmdfull_en", cmd_en, 0);
        chk("st_cmdfull_busy", busy, 1);
        repeat (2) begin
            cyc(); #1;
            chk("st_cmdfull_en", cmd_en, 0);
            chk("st_cmdfull_bl", cmd_bl, 3);
        end
        cyc(); cmd_full = 0; #1;
        chk("st_cmd_en", cmd_en, 1);
        chk("st_cmd_addr", cmd_byte_addr, 30'h200);
        cyc(); r0_req = 0; r0_valid = 0; #1;
        chk("st_done", r0_done, 1);
        cyc(); #1;
        chk("st_pushes", push_q.size() - p0, 4);
        for (int k = 0; k < 4; k++)
            chk("st_data", push_q[p0 + k], 32'h3000_0000 + k);
        chk("st_cmds", cmds - c0, 1);

        // Rejection of oversize bursts, then address alignment
        p0 = push_q.size(); c0 = cmds;
        r1_req = 1; r1_addr = 30'h400; r1_len = 40; r1_valid = 1;
        cyc(); #1;
        chk("rj40_done_err", {r1_done, r1_err}, 2'b11);
        chk("rj40_no_ready", r1_ready, 0);
        r1_req = 0;
        cyc(); r1_req = 1; r1_len = 32; #1;
        chk("rj40_idle", {busy, r1_done}, 0);
        cyc(); #1;
        chk("rj32_done_err", {r1_done, r1_err}, 2'b11);
        r1_req = 0; r1_valid = 0;
        cyc();
        chk("rj_cmd_bl_kept", cmd_bl, 3);
        off0 = idx0; dbase0 = 32'h5000_0000;
        r0_req = 1; r0_addr = 30'h103; r0_len = 0; r0_valid = 1;
        cyc(); #1;
        chk("al_push", wr_en, 1);
        cyc(); #1;
        chk("al_cmd_en", cmd_en, 1);
        chk("al_cmd_addr", cmd_byte_addr, 30'h100);
        chk("al_cmd_bl", cmd_bl, 0);
        cyc(); r0_req = 0; r0_valid = 0; #1;
        chk("al_done", {r0_done, r0_err}, 2'b10);
        cyc(); #1;
        chk("rj_pushes", push_q.size() - p0, 1);
        chk("rj_cmds", cmds - c0, 1);

        // Calibration gating, then reset mid-burst
        c0 = cmds; g0 = grant_q.size();
        calib_done = 0;
        r0_req = 1; r0_addr = 30'h500; r0_len = 3; r0_valid = 1;
        repeat (20) begin
            cyc(); #1;
            chk("cal_idle", {busy, r0_ready, wr_en}, 0);
        end
        cyc(); calib_done = 1; #1;
        chk("cal_rise_busy", busy, 0);
        cyc(); #1;
        chk("cal_grant", {busy, r0_ready}, 2'b11);
        cyc(); reset = 1; #1;
        cyc(); r0_req = 0; r0_valid = 0; #1;
        chk("mr_busy", busy, 0);
        chk("mr_outs", {wr_en, r0_ready, cmd_en, r0_done}, 0);
        chk("mr_cmd_bl", cmd_bl, 0);
        chk("mr_cmd_addr", cmd_byte_addr, 0);
        cyc(); reset = 0;
        repeat (5) cyc();
        #1;
        chk("mr_no_cmd", cmds - c0, 0);
        chk("mr_no_done", grant_q.size() - g0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
